// File: rtl/ifmap_window_buffer.sv
// Stores NUM_TS binary spike ifmaps and streams K-row convolution windows
// as packets to the PE array, with replay and a sticky illegal-write flag.
module ifmap_window_buffer #(
   parameter int DIM        = 25,
   parameter int K          = 5,
   parameter int NUM_TS     = 2,
   parameter int PACK_WIDTH = 64,
   parameter int ADDR_W     = 10,
   parameter int TS_W       = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [TS_W-1:0]       wr_ts,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic                  wr_data,
   input  logic                  load_done,
   input  logic                  replay,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [PACK_WIDTH-1:0] out_data,
   output logic                  stream_done,
   output logic                  err
);
   localparam int OUT_DIM = DIM - K + 1;
   localparam int PIX     = DIM * DIM;
   localparam int TI_W    = (NUM_TS > 1) ? $clog2(NUM_TS) : 1;
   localparam int RI_W    = (DIM > 1) ? $clog2(DIM) : 1;
   localparam logic [TS_W-1:0] TS_LAST = TS_W'(NUM_TS - 1);
   localparam logic [7:0]      R_LAST  = 8'(OUT_DIM - 1);
   localparam logic [7:0]      K_LAST  = 8'(K - 1);

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_STREAM = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   state_t                  state_r;
   logic [DIM-1:0]          mem_r [NUM_TS][DIM];
   logic [TS_W-1:0]         ts_r;
   logic [7:0]              r_r;
   logic [7:0]              k_r;
   logic                    out_valid_r;
   logic                    stream_done_r;
   logic                    err_r;
   logic [PACK_WIDTH-1:0]   out_data_r;

   logic                    wr_fire_s;
   logic                    wr_legal_s;
   logic [TI_W-1:0]         wr_tsi_s;
   logic [RI_W-1:0]         wr_row_s;
   logic [RI_W-1:0]         wr_col_s;
   logic                    start_s;
   logic                    last_s;
   logic                    fwd_s;
   logic [TS_W-1:0]         nxt_ts_s;
   logic [7:0]              nxt_r_s;
   logic [7:0]              nxt_k_s;
   logic [RI_W-1:0]         nxt_row_s;
   logic [DIM-1:0]          row_base_s;
   logic [DIM-1:0]          fwd_mask_s;
   logic [DIM-1:0]          row_s;
   logic [PACK_WIDTH-1:0]   pkt_s;

   function automatic logic [PACK_WIDTH-1:0] build_packet(
      input logic [TS_W-1:0] ts_idx,
      input logic [7:0]      r,
      input logic [7:0]      k,
      input logic [DIM-1:0]  row
   );
      logic [PACK_WIDTH-1:0] p;
      p = '0;
      p[DIM-1:0] = row;
      p[PACK_WIDTH-1 -: TS_W] = ts_idx + TS_W'(1);
      p[PACK_WIDTH-TS_W-1 -: 8] = r;
      p[PACK_WIDTH-TS_W-9 -: 8] = k;
      return p;
   endfunction

   assign wr_ready    = !rst && (state_r != ST_STREAM);
   assign out_valid   = out_valid_r;
   assign out_data    = out_data_r;
   assign stream_done = stream_done_r;
   assign err         = err_r;

   // Write-port decode: handshake, legality and row/column split of the address.
   always_comb begin
      wr_fire_s  = wr_valid && wr_ready;
      wr_legal_s = (wr_ts != '0) && ({1'b0, wr_ts} <= (TS_W+1)'(NUM_TS)) &&
                   ({1'b0, wr_addr} < (ADDR_W+1)'(PIX));
      wr_tsi_s   = TI_W'(wr_ts - TS_W'(1));
      wr_row_s   = RI_W'(wr_addr / ADDR_W'(DIM));
      wr_col_s   = RI_W'(wr_addr % ADDR_W'(DIM));
   end

   // Next packet coordinates and payload; a write landing in the same cycle as a
   // start is forwarded so the first packet already sees it.
   always_comb begin
      start_s = ((state_r == ST_LOAD) && load_done) ||
                ((state_r == ST_HOLD) && (load_done || replay));
      last_s  = (ts_r == TS_LAST) && (r_r == R_LAST) && (k_r == K_LAST);
      if (state_r != ST_STREAM) begin
         nxt_ts_s = '0;
         nxt_r_s  = 8'd0;
         nxt_k_s  = 8'd0;
      end else if (k_r != K_LAST) begin
         nxt_ts_s = ts_r;
         nxt_r_s  = r_r;
         nxt_k_s  = k_r + 8'd1;
      end else if (r_r != R_LAST) begin
         nxt_ts_s = ts_r;
         nxt_r_s  = r_r + 8'd1;
         nxt_k_s  = 8'd0;
      end else begin
         nxt_ts_s = ts_r + TS_W'(1);
         nxt_r_s  = 8'd0;
         nxt_k_s  = 8'd0;
      end
      nxt_row_s  = RI_W'(nxt_r_s + nxt_k_s);
      row_base_s = mem_r[TI_W'(nxt_ts_s)][nxt_row_s];
      fwd_mask_s = '0;
      fwd_mask_s[wr_col_s] = 1'b1;
      fwd_s = wr_fire_s && wr_legal_s && (wr_tsi_s == TI_W'(nxt_ts_s)) &&
              (wr_row_s == nxt_row_s);
      row_s = fwd_s ? ((row_base_s & ~fwd_mask_s) | (wr_data ? fwd_mask_s : '0))
                    : row_base_s;
      pkt_s = build_packet(nxt_ts_s, nxt_r_s, nxt_k_s, row_s);
   end

   // Storage, error flag and the LOAD/STREAM/HOLD sequencer with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_LOAD;
         ts_r          <= '0;
         r_r           <= 8'd0;
         k_r           <= 8'd0;
         out_valid_r   <= 1'b0;
         out_data_r    <= '0;
         stream_done_r <= 1'b0;
         err_r         <= 1'b0;
         for (int t = 0; t < NUM_TS; t++) begin
            for (int y = 0; y < DIM; y++) begin
               mem_r[t][y] <= '0;
            end
         end
      end else begin
         stream_done_r <= 1'b0;
         if (wr_fire_s && wr_legal_s) begin
            mem_r[wr_tsi_s][wr_row_s][wr_col_s] <= wr_data;
         end else if (wr_fire_s) begin
            err_r <= 1'b1;
         end
         case (state_r)
            ST_LOAD, ST_HOLD: begin
               if (start_s) begin
                  state_r     <= ST_STREAM;
                  out_valid_r <= 1'b1;
                  ts_r        <= nxt_ts_s;
                  r_r         <= nxt_r_s;
                  k_r         <= nxt_k_s;
                  out_data_r  <= pkt_s;
               end
            end
            ST_STREAM: begin
               if (out_ready && last_s) begin
                  out_valid_r   <= 1'b0;
                  stream_done_r <= 1'b1;
                  state_r       <= ST_HOLD;
               end else if (out_ready) begin
                  ts_r       <= nxt_ts_s;
                  r_r        <= nxt_r_s;
                  k_r        <= nxt_k_s;
                  out_data_r <= pkt_s;
               end
            end
            default: begin
               state_r     <= ST_LOAD;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: doc/ifmap_window_buffer.md
Name: ifmap_window_buffer

Overview:
- Clocked, parametrised successor to the CSP ifmap store of the SNN conv layer.
- Captures binary spike ifmaps for NUM_TS timesteps through a valid/ready write port.
- After load_done, streams convolution row-window packets to the PE array: per timestep, per output row r, K packets each carrying one full ifmap row r+k.
- Supports replay of the stored frames without reloading, and flags illegal writes.

Parameters:
DIM, 25, ifmap width/height (square)
K, 5, filter size; OUT_DIM = DIM-K+1 (21 at defaults)
NUM_TS, 2, timesteps stored
PACK_WIDTH, 64, output packet width; must be >= DIM+TS_W+16
ADDR_W, 10, write address width; must be >= clog2(DIM*DIM)
TS_W, 2, timestep field width; must be >= clog2(NUM_TS+1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid&wr_ready
wr_ts  in  TS_W  timestep, 1-based (1..NUM_TS)
wr_addr  in  ADDR_W  row-major pixel address, row*DIM+col
wr_data  in  1  spike bit
load_done  in  1  single-cycle pulse: loading finished, start streaming
replay  in  1  single-cycle pulse: re-stream stored frames
out_valid  out  1  packet valid
out_ready  in  1  consumer ready
out_data  out  PACK_WIDTH  packet
stream_done  out  1  one-cycle pulse after last packet handshake
err  out  1  sticky illegal-write flag

Behaviour:
- Single clock (clk); reset (rst) is synchronous and active-high.
- Reset: state=LOAD, storage cleared to 0, out_valid=0, out_data=0, stream_done=0, err=0, wr_ready=0 during the rst cycle and 1 from the first cycle after rst drops.
- States: LOAD, STREAM, HOLD.
- LOAD:
  - wr_ready=1.
  - On a write handshake, bit [wr_ts-1][wr_addr] = wr_data. The write is visible to a stream starting the next cycle.
  - Illegal write: wr_ts==0, wr_ts>NUM_TS, or wr_addr>=DIM*DIM. The write is dropped, the handshake still completes, and err is set. err stays set until rst.
  - Repeated writes to the same location: last write wins.
  - load_done -> STREAM. If load_done coincides with a write, the write is committed first.
  - replay is ignored in LOAD.
- STREAM:
  - wr_ready=0; load_done and replay are ignored.
  - out_valid rises the cycle after the load_done/replay pulse is sampled.
  - Packet order: ts 1..NUM_TS (outer), r 0..OUT_DIM-1, k 0..K-1 (inner). Total NUM_TS*OUT_DIM*K packets (210 at defaults).
  - Packet format:
    - [DIM-1:0]: row r+k of timestep ts; bit c = pixel (r+k, c).
    - [PACK_WIDTH-1 -: TS_W]: ts (1-based).
    - Next 8 bits below the ts field: r.
    - Next 8 bits below r: k.
    - All remaining bits: 0.
  - out_data and out_valid are registered. While out_valid && !out_ready, out_data is held stable.
  - After a handshake, the next packet is presented in the following cycle. No bubbles: out_valid stays 1 until the final packet.
  - Final packet handshake: out_valid falls next cycle, stream_done pulses that same cycle, state -> HOLD.
- HOLD:
  - wr_ready=1 and writes behave exactly as in LOAD (HOLD equals LOAD plus replay enabled).
  - load_done or replay -> STREAM, starting again at ts=1, r=0, k=0. Storage is retained; only written locations change.
  - load_done and replay in the same cycle are treated as a single start.
- rst mid-stream: immediate return to reset state and storage cleared. No stream_done pulse.
- Counters: r wraps OUT_DIM-1 -> 0 with ts increment; k wraps K-1 -> 0 with r increment. No counter exceeds its bound.

Test Plan:
- Reset check: after rst, out_valid=0, err=0, wr_ready=1; load_done with all-zero storage -> 210 packets, all row bits 0. First packet ts=1, r=0, k=0; last packet ts=2, r=20, k=4; stream_done pulses once.
- Diagonal load: ts1 writes 1 at addr i*26 (i=0..24), ts2 all zeros. Packet ts=1, r=3, k=2 has data bit5=1 only (row 5); all ts=2 packets have data 0.
- Backpressure: hold out_ready=0 for 7 cycles mid-stream. out_data is unchanged across those cycles, no packet is lost or duplicated, and the count is still 210.
- Illegal writes: wr_ts=0, wr_ts=3, wr_addr=625 -> err=1, storage unchanged, handshake completes. A following legal write (ts=1, addr=0, data=1) lands normally.
- Replay: after stream_done, overwrite ts=2 addr 624 with 1, then pulse replay. The second stream has packet ts=2, r=20, k=4 with data bit24=1. load_done and any writes during STREAM are ignored (wr_ready=0).
- Reset mid-stream: assert rst after packet 50 -> next cycle out_valid=0. A fresh load_done streams all-zero data starting at ts=1, r=0, k=0.
